eth_rx_frame_ctrl: RTL and testbench

//  MII receive sequencer. Samples rx_dv/rx_er/dataout_rx once per clk and detects preamble+SFD.

---
 rtl/eth_rx_frame_ctrl.sv | 125 ++++++++++++
 tb/tb_eth_rx_frame_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_ctrl.sv
// MII receive sequencer: finds preamble+SFD, packs nibbles into bytes for the
// frame buffer and holds the completed frame until the consumer acknowledges it.
module eth_rx_frame_ctrl #(
  parameter int unsigned MAX_BYTES = 64,
  parameter int unsigned MIN_BYTES = 8,
  parameter int unsigned ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_dv,
  input  logic              rx_er,
  input  logic [3:0]        dataout_rx,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_wdata,
  output logic              frm_valid,
  output logic [ADDR_W:0]   frm_len,
  output logic              frm_err,
  input  logic              frm_ack,
  output logic [7:0]        drop_cnt
);

  localparam logic [ADDR_W:0] MAX_B = (ADDR_W+1)'(MAX_BYTES);
  localparam logic [ADDR_W:0] MIN_B = (ADDR_W+1)'(MIN_BYTES);

  typedef enum logic [2:0] {IDLE, PRE, SKIP, DATA, HOLD} state_t;

  state_t          state, state_nx;
  logic            dv_q;
  logic            start;
  logic            good;
  logic [3:0]      pre_cnt;
  logic [3:0]      low_nib;
  logic [ADDR_W:0] byte_cnt;
  logic            phase;
  logic            err;
  logic            ovf;

  assign start = rx_dv & ~dv_q;
  assign good  = rx_dv & ~rx_er;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start && !rx_er && dataout_rx == 4'h5) state_nx = PRE;
      PRE: begin
        if (good && dataout_rx == 4'h5)                      state_nx = PRE;
        else if (good && dataout_rx == 4'hD && pre_cnt >= 4'd7) state_nx = DATA;
        else                                                  state_nx = SKIP;
      end
      SKIP: if (!rx_dv) state_nx = IDLE;
      DATA: if (!rx_dv) state_nx = HOLD;
      HOLD: if (frm_ack && frm_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: preamble count, nibble packing, buffer writes, frame status
  always_ff @(posedge clk) begin
    if (rst) begin
      dv_q      <= 1'b1;
      pre_cnt   <= '0;
      low_nib   <= '0;
      byte_cnt  <= '0;
      phase     <= 1'b0;
      err       <= 1'b0;
      ovf       <= 1'b0;
      buf_we    <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
      frm_valid <= 1'b0;
      frm_len   <= '0;
      frm_err   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      dv_q   <= rx_dv;
      buf_we <= 1'b0;
      case (state)
        IDLE: pre_cnt <= 4'd1;
        PRE: begin
          if (good && dataout_rx == 4'h5 && pre_cnt != 4'd15) pre_cnt <= pre_cnt + 4'd1;
          if (state_nx == DATA) begin
            byte_cnt <= '0;
            phase    <= 1'b0;
            err      <= 1'b0;
            ovf      <= 1'b0;
          end
        end
        DATA: begin
          if (rx_dv) begin
            phase <= ~phase;
            if (rx_er) err <= 1'b1;
            if (!phase) begin
              low_nib <= dataout_rx;
            end else if (byte_cnt < MAX_B) begin
              buf_we    <= 1'b1;
              buf_addr  <= byte_cnt[ADDR_W-1:0];
              buf_wdata <= {dataout_rx, low_nib};
              byte_cnt  <= byte_cnt + (ADDR_W+1)'(1);
            end else begin
              ovf <= 1'b1;
            end
          end else begin
            frm_valid <= 1'b1;
            frm_len   <= byte_cnt;
            frm_err   <= err | ovf | phase | (byte_cnt < MIN_B);
          end
        end
        HOLD: begin
          if (frm_ack) frm_valid <= 1'b0;
          if (start && drop_cnt != 8'd255) drop_cnt <= drop_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Directed bench for eth_rx_frame_ctrl with hand-computed expectations.
module tb_eth_rx_frame_ctrl;

  logic       clk;
  logic       rst;
  logic       rx_dv;
  logic       rx_er;
  logic [3:0] dataout_rx;
  logic       buf_we;
  logic [5:0] buf_addr;
  logic [7:0] buf_wdata;
  logic       frm_valid;
  logic [6:0] frm_len;
  logic       frm_err;
  logic       frm_ack;
  logic [7:0] drop_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  int wr_total = 0;
  int wr_snap;

  eth_rx_frame_ctrl #(.MAX_BYTES(64), .MIN_BYTES(8), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_er(rx_er), .dataout_rx(dataout_rx),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .frm_valid(frm_valid), .frm_len(frm_len), .frm_err(frm_err),
    .frm_ack(frm_ack), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every buffer write, sampled mid-cycle
  always @(negedge clk) if (buf_we) wr_total++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic er, input logic [3:0] nib);
    rx_dv = dv; rx_er = er; dataout_rx = nib;
    @(posedge clk); #1;
  endtask

  task automatic preamble(input int n5);
    for (int i = 0; i < n5; i++) drive(1'b1, 1'b0, 4'h5);
    drive(1'b1, 1'b0, 4'hD);
  endtask

  task automatic send_bytes(input int first, input int n, input int er_byte, input bit expect_wr);
    logic [7:0] d;
    for (int b = first; b < first + n; b++) begin
      d = 8'(b);
      drive(1'b1, b == er_byte, d[3:0]);
      drive(1'b1, 1'b0, d[7:4]);
      if (expect_wr && b < 64)
        check("wr", {17'd0, buf_we, buf_addr, buf_wdata}, {17'd0, 1'b1, 6'(b), d});
      else
        check("nowr", {31'd0, buf_we}, 32'd0);
    end
  endtask

  task automatic end_frame(input int exp_len, input logic exp_err);
    drive(1'b0, 1'b0, 4'h0);
    check("valid", {31'd0, frm_valid}, 32'd1);
    check("len", {25'd0, frm_len}, 32'(exp_len));
    check("err", {31'd0, frm_err}, {31'd0, exp_err});
  endtask

  task automatic ack_frame();
    frm_ack = 1'b1;
    drive(1'b0, 1'b0, 4'h0);
    frm_ack = 1'b0;
    check("ack_valid", {31'd0, frm_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; rx_dv = 1'b0; rx_er = 1'b0; dataout_rx = 4'h0; frm_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", {31'd0, buf_we}, 32'd0);
    check("rst_valid", {31'd0, frm_valid}, 32'd0);
    check("rst_len", {25'd0, frm_len}, 32'd0);
    check("rst_err", {31'd0, frm_err}, 32'd0);
    check("rst_drop", {24'd0, drop_cnt}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'h0);

    // 16-byte frame, long preamble
    wr_snap = wr_total;
    preamble(15);
    send_bytes(0, 16, -1, 1'b1);
    end_frame(16, 1'b0);
    check("cnt16", 32'(wr_total - wr_snap), 32'd16);
    drive(1'b0, 1'b0, 4'h0);
    check("hold_valid", {31'd0, frm_valid}, 32'd1);
    check("hold_len", {25'd0, frm_len}, 32'd16);
    ack_frame();

    // 70-byte frame truncated at 64, minimum preamble
    wr_snap = wr_total;
    preamble(7);
    send_bytes(0, 70, -1, 1'b1);
    end_frame(64, 1'b1);
    check("cnt64", 32'(wr_total - wr_snap), 32'd64);
    ack_frame();

    // rx_er on byte 3 of 12
    wr_snap = wr_total;
    preamble(7);
    send_bytes(0, 12, 3, 1'b1);
    end_frame(12, 1'b1);
    check("cnt12er", 32'(wr_total - wr_snap), 32'd12);
    ack_frame();

    // 25 nibbles
    preamble(7);
    send_bytes(0, 12, -1, 1'b1);
    drive(1'b1, 1'b0, 4'hA);
    end_frame(12, 1'b1);
    ack_frame();

    // runt frame
    preamble(7);
    send_bytes(0, 4, -1, 1'b1);
    end_frame(4, 1'b1);
    ack_frame();

    // exactly MIN_BYTES is not a runt
    preamble(7);
    send_bytes(0, 8, -1, 1'b1);
    end_frame(8, 1'b0);
    ack_frame();

    // short preamble goes to SKIP
    wr_snap = wr_total;
    preamble(3);
    send_bytes(0, 4, -1, 1'b0);
    drive(1'b0, 1'b0, 4'h0);
    drive(1'b0, 1'b0, 4'h0);
    check("skip_valid", {31'd0, frm_valid}, 32'd0);
    check("skip_cnt", 32'(wr_total - wr_snap), 32'd0);

    // second frame while first is held; ack arrives mid-frame
    preamble(7);
    send_bytes(0, 10, -1, 1'b1);
    end_frame(10, 1'b0);
    wr_snap = wr_total;
    preamble(7);
    send_bytes(0, 3, -1, 1'b0);
    check("drop1", {24'd0, drop_cnt}, 32'd1);
    check("keep_len", {25'd0, frm_len}, 32'd10);
    check("keep_err", {31'd0, frm_err}, 32'd0);
    frm_ack = 1'b1;
    drive(1'b1, 1'b0, 4'h3);
    frm_ack = 1'b0;
    check("midack_valid", {31'd0, frm_valid}, 32'd0);
    drive(1'b1, 1'b0, 4'h0);
    send_bytes(4, 6, -1, 1'b0);
    drive(1'b0, 1'b0, 4'h0);
    drive(1'b0, 1'b0, 4'h0);
    check("drop_valid", {31'd0, frm_valid}, 32'd0);
    check("drop_cnt", {24'd0, drop_cnt}, 32'd1);
    check("drop_wr", 32'(wr_total - wr_snap), 32'd0);

    // reset mid-frame with rx_dv held high
    preamble(7);
    send_bytes(0, 5, -1, 1'b1);
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'h5);
    check("mrst_we", {31'd0, buf_we}, 32'd0);
    check("mrst_valid", {31'd0, frm_valid}, 32'd0);
    check("mrst_drop", {24'd0, drop_cnt}, 32'd0);
    rst = 1'b0;
    wr_snap = wr_total;
    drive(1'b1, 1'b0, 4'h5);
    drive(1'b1, 1'b0, 4'hD);
    send_bytes(6, 4, -1, 1'b0);
    drive(1'b0, 1'b0, 4'h0);
    drive(1'b0, 1'b0, 4'h0);
    check("mrst_cnt", 32'(wr_total - wr_snap), 32'd0);
    check("mrst_valid2", {31'd0, frm_valid}, 32'd0);
    preamble(7);
    send_bytes(0, 8, -1, 1'b1);
    end_frame(8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
